// File: rtl/n64_si_eeprom_if.sv
// System clock/reset bundle for the SI EEPROM responder.
// The block consumes clk/reset through the "sys" modport; whoever generates
// the clock and reset (board logic or a bench) uses the "master" modport.
interface if_system;
    logic clk;
    logic reset;

    modport sys    (input  clk, input  reset);
    modport master (output clk, output reset);
endinterface

// File: rtl/n64_si_eeprom.sv
// Joybus EEPROM command responder (info / read block / write block).
// Decodes a received SI frame, moves one 64-bit block through the memory
// request port and loads the response words into the SI shift register.
// Build option: define EEPROM_16K_EN to let eeprom_16k select 16 Kbit mode;
// without it the device is always 4 Kbit (id 0x80, 6-bit block index).
//
// Memory handshake: mem_read/mem_write is a level request that stays high,
// with mem_address/mem_wdata stable, until the cycle after a one-cycle
// mem_ack; mem_rdata is valid only in the mem_ack cycle. mem_ack seen while
// no request is outstanding is ignored.
module n64_si_eeprom (
    if_system.sys        sys,
    input  logic         eeprom_enabled,
    input  logic         eeprom_16k,
    input  logic         rx_ready,
    input  logic [6:0]   rx_length,
    input  logic [80:0]  rx_data,
    output logic         rx_reset,
    output logic         tx_reset,
    output logic         tx_start,
    input  logic         tx_busy,
    output logic [2:0]   tx_wmask,
    output logic [6:0]   tx_length,
    output logic [31:0]  tx_data,
    output logic         mem_read,
    output logic         mem_write,
    output logic [7:0]   mem_address,
    output logic [63:0]  mem_wdata,
    input  logic [63:0]  mem_rdata,
    input  logic         mem_ack,
    output logic [3:0]   debug_state
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_READ  = 4'd2,
        S_LOAD_LO   = 4'd3,
        S_MEM_WRITE = 4'd4,
        S_START     = 4'd5,
        S_WAIT_BUSY = 4'd6,
        S_WAIT_DONE = 4'd7
    } state_t;

    state_t       state, next_state;
    logic [6:0]   frame_len, next_frame_len;
    logic [80:0]  frame_data, next_frame_data;
    logic [31:0]  rdata_lo, next_rdata_lo;

    logic         next_rx_reset;
    logic         next_tx_start;
    logic [2:0]   next_tx_wmask;
    logic [6:0]   next_tx_length;
    logic [31:0]  next_tx_data;
    logic         next_mem_read;
    logic         next_mem_write;
    logic [7:0]   next_mem_address;
    logic [63:0]  next_mem_wdata;

    logic         is_16k;
    logic         cmd_info;
    logic         cmd_read;
    logic         cmd_write;
    logic [7:0]   block_index;
    logic [7:0]   block_address;
    logic [7:0]   id_byte;
    logic         unused_ok;

`ifdef EEPROM_16K_EN
    assign is_16k    = eeprom_16k;
    assign unused_ok = frame_data[0];
`else
    assign is_16k    = 1'b0;
    assign unused_ok = &{frame_data[0], eeprom_16k};
`endif

    // The shifter's transmit path is held in reset together with this block.
    assign tx_reset    = sys.reset;
    assign debug_state = state;

    // Command classification of the latched frame; length must match exactly.
    always_comb begin
        cmd_info      = (frame_len == 7'd9)
                        && ((frame_data[8:1] == 8'h00) || (frame_data[8:1] == 8'hFF));
        cmd_read      = (frame_len == 7'd17) && (frame_data[16:9] == 8'h04);
        cmd_write     = (frame_len == 7'd81) && (frame_data[80:73] == 8'h05);
        block_index   = cmd_write ? frame_data[72:65] : frame_data[8:1];
        block_address = is_16k ? block_index : {2'b00, block_index[5:0]};
        id_byte       = is_16k ? 8'hC0 : 8'h80;
    end

    // Next-state and next-output logic; every output is registered.
    always_comb begin
        next_state       = state;
        next_frame_len   = frame_len;
        next_frame_data  = frame_data;
        next_rdata_lo    = rdata_lo;
        next_rx_reset    = 1'b0;
        next_tx_start    = 1'b0;
        next_tx_wmask    = 3'b000;
        next_tx_length   = tx_length;
        next_tx_data     = tx_data;
        next_mem_read    = mem_read;
        next_mem_write   = mem_write;
        next_mem_address = mem_address;
        next_mem_wdata   = mem_wdata;

        case (state)
            S_IDLE: begin
                // While rx_reset is being presented the shifter still shows
                // the old frame as ready; it must not be taken a second time.
                if (rx_ready && !rx_reset) begin
                    next_frame_len  = rx_length;
                    next_frame_data = rx_data;
                    next_state      = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!eeprom_enabled) begin
                    next_rx_reset = 1'b1;
                    next_state    = S_IDLE;
                end else if (cmd_info) begin
                    next_tx_data   = {8'h00, id_byte, 16'h0000};
                    next_tx_wmask  = 3'b001;
                    next_tx_length = 7'd24;
                    next_state     = S_START;
                end else if (cmd_read) begin
                    next_mem_read    = 1'b1;
                    next_mem_address = block_address;
                    next_state       = S_MEM_READ;
                end else if (cmd_write) begin
                    next_mem_write   = 1'b1;
                    next_mem_address = block_address;
                    next_mem_wdata   = frame_data[64:1];
                    next_state       = S_MEM_WRITE;
                end else begin
                    next_rx_reset = 1'b1;
                    next_state    = S_IDLE;
                end
            end
            S_MEM_READ: begin
                if (mem_ack) begin
                    next_mem_read = 1'b0;
                    next_rdata_lo = mem_rdata[31:0];
                    next_tx_data  = mem_rdata[63:32];
                    next_tx_wmask = 3'b001;
                    next_state    = S_LOAD_LO;
                end
            end
            S_LOAD_LO: begin
                next_tx_data   = rdata_lo;
                next_tx_wmask  = 3'b010;
                next_tx_length = 7'd64;
                next_state     = S_START;
            end
            S_MEM_WRITE: begin
                if (mem_ack) begin
                    next_mem_write = 1'b0;
                    next_tx_data   = 32'h0000_0000;
                    next_tx_wmask  = 3'b001;
                    next_tx_length = 7'd8;
                    next_state     = S_START;
                end
            end
            S_START: begin
                next_tx_start = 1'b1;
                next_rx_reset = 1'b1;
                next_state    = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    next_state = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge sys.clk) begin
        if (sys.reset) begin
            state       <= S_IDLE;
            frame_len   <= 7'd0;
            frame_data  <= 81'd0;
            rdata_lo    <= 32'd0;
            rx_reset    <= 1'b0;
            tx_start    <= 1'b0;
            tx_wmask    <= 3'b000;
            tx_length   <= 7'd0;
            tx_data     <= 32'd0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= 8'd0;
            mem_wdata   <= 64'd0;
        end else begin
            state       <= next_state;
            frame_len   <= next_frame_len;
            frame_data  <= next_frame_data;
            rdata_lo    <= next_rdata_lo;
            rx_reset    <= next_rx_reset;
            tx_start    <= next_tx_start;
            tx_wmask    <= next_tx_wmask;
            tx_length   <= next_tx_length;
            tx_data     <= next_tx_data;
            mem_read    <= next_mem_read;
            mem_write   <= next_mem_write;
            mem_address <= next_mem_address;
            mem_wdata   <= next_mem_wdata;
        end
    end

endmodule

// File: tb/tb_n64_si_eeprom.sv
// Bench for n64_si_eeprom: table of frames with expected responses, a
// scoreboard queue of expected output events, memory and TX-busy models,
// and hand sequences for latency and reset-during-request behaviour.
module tb_n64_si_eeprom;

    localparam logic [1:0] K_BAD   = 2'd0;
    localparam logic [1:0] K_INFO  = 2'd1;
    localparam logic [1:0] K_READ  = 2'd2;
    localparam logic [1:0] K_WRITE = 2'd3;

`ifdef EEPROM_16K_EN
    localparam bit         BUILD_16K = 1'b1;
    localparam logic [7:0] ID16      = 8'hC0;
`else
    localparam bit         BUILD_16K = 1'b0;
    localparam logic [7:0] ID16      = 8'h80;
`endif

    typedef struct {
        logic [6:0]  len;
        logic [80:0] data;
        logic        en;
        logic        k16;
        logic [63:0] rdata;
        logic [1:0]  kind;
        logic [7:0]  addr;
        logic [31:0] word;
    } vec_t;

    if_system sys_if ();

    logic         eeprom_enabled;
    logic         eeprom_16k;
    logic         rx_ready;
    logic [6:0]   rx_length;
    logic [80:0]  rx_data;
    logic         rx_reset;
    logic         tx_reset;
    logic         tx_start;
    logic         tx_busy;
    logic [2:0]   tx_wmask;
    logic [6:0]   tx_length;
    logic [31:0]  tx_data;
    logic         mem_read;
    logic         mem_write;
    logic [7:0]   mem_address;
    logic [63:0]  mem_wdata;
    logic [63:0]  mem_rdata;
    logic         mem_ack;
    logic [3:0]   debug_state;

    logic [71:0]  exp_q[$];
    int           checks;
    int           failures;
    int           cyc;
    int           mem_delay;
    logic [63:0]  mem_rdata_val;
    int           t_rx, t_req, t_fall, t_ack, t_start;
    int           ack_count;
    logic         prev_rx, prev_read, prev_write;
    vec_t         vecs[13];

    n64_si_eeprom dut (
        .sys            (sys_if),
        .eeprom_enabled (eeprom_enabled),
        .eeprom_16k     (eeprom_16k),
        .rx_ready       (rx_ready),
        .rx_length      (rx_length),
        .rx_data        (rx_data),
        .rx_reset       (rx_reset),
        .tx_reset       (tx_reset),
        .tx_start       (tx_start),
        .tx_busy        (tx_busy),
        .tx_wmask       (tx_wmask),
        .tx_length      (tx_length),
        .tx_data        (tx_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack),
        .debug_state    (debug_state)
    );

    // Clock.
    initial begin
        sys_if.clk = 1'b0;
        forever #5 sys_if.clk = ~sys_if.clk;
    end

    // Memory model: answers each request with one ack after mem_delay cycles.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 64'd0;
        forever begin
            @(negedge sys_if.clk);
            if ((mem_read || mem_write) && !sys_if.reset) begin
                repeat (mem_delay) @(posedge sys_if.clk);
                #1;
                mem_ack   = 1'b1;
                mem_rdata = mem_rdata_val;
                @(posedge sys_if.clk);
                #1;
                mem_ack   = 1'b0;
            end
        end
    end

    // Shifter transmit model: busy for a while after each tx_start.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge sys_if.clk);
            if (tx_start) begin
                @(posedge sys_if.clk);
                #1;
                tx_busy = 1'b1;
                repeat (8) @(posedge sys_if.clk);
                #1;
                tx_busy = 1'b0;
            end
        end
    end

    function automatic logic [71:0] ev(input logic [7:0] tag, input logic [63:0] val);
        return {tag, val};
    endfunction

    function automatic logic [80:0] f_info(input logic [7:0] cmd);
        return {72'd0, cmd, 1'b1};
    endfunction

    function automatic logic [80:0] f17(input logic [7:0] cmd, input logic [7:0] idx);
        return {64'd0, cmd, idx, 1'b1};
    endfunction

    function automatic logic [80:0] f81(input logic [7:0] cmd, input logic [7:0] idx,
                                        input logic [63:0] data);
        return {cmd, idx, data, 1'b1};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard pop for one observed DUT event.
    task automatic expect_event(input string name, input logic [7:0] tag, input logic [63:0] val);
        logic [71:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s: unexpected event tag %0d value %h, nothing expected", name, tag, val);
        end else begin
            e = exp_q.pop_front();
            if (e !== {tag, val}) begin
                failures++;
                $display("FAIL %s: got tag %0d value %h expected tag %0d value %h",
                         name, tag, val, e[71:64], e[63:0]);
            end
        end
    endtask

    // Observe outputs once per cycle, away from the active edge.
    task automatic monitor();
        if (tx_wmask != 3'b000) expect_event("tx_word", {5'd0, tx_wmask}, {32'd0, tx_data});
        if (tx_start) begin
            if (t_start < 0) t_start = cyc;
            expect_event("tx_start", 8'd8, {57'd0, tx_length});
        end
        if (rx_reset) expect_event("rx_reset", 8'd64, 64'd0);
        if (mem_read && !prev_read) begin
            t_req = cyc;
            expect_event("mem_read", 8'd16, {56'd0, mem_address});
        end
        if (mem_write && !prev_write) begin
            t_req = cyc;
            expect_event("mem_write_addr", 8'd32, {56'd0, mem_address});
            expect_event("mem_wdata", 8'd33, mem_wdata);
        end
        if ((prev_read && !mem_read) || (prev_write && !mem_write)) t_fall = cyc;
        if (mem_ack) begin
            t_ack = cyc;
            ack_count++;
        end
        if (rx_ready && !prev_rx) t_rx = cyc;
        prev_rx    = rx_ready;
        prev_read  = mem_read;
        prev_write = mem_write;
    endtask

    // One clock: monitor at negedge, then step past the posedge. The frame
    // is cleared in the shifter at the edge where rx_reset is sampled.
    task automatic tick();
        logic clr;
        @(negedge sys_if.clk);
        clr = rx_reset;
        monitor();
        @(posedge sys_if.clk);
        #1;
        cyc++;
        if (clr) rx_ready = 1'b0;
    endtask

    task automatic push_expected(input vec_t v);
        case (v.kind)
            K_INFO: begin
                exp_q.push_back(ev(8'd1, {32'd0, v.word}));
                exp_q.push_back(ev(8'd8, 64'd24));
                exp_q.push_back(ev(8'd64, 64'd0));
            end
            K_READ: begin
                exp_q.push_back(ev(8'd16, {56'd0, v.addr}));
                exp_q.push_back(ev(8'd1, {32'd0, v.rdata[63:32]}));
                exp_q.push_back(ev(8'd2, {32'd0, v.rdata[31:0]}));
                exp_q.push_back(ev(8'd8, 64'd64));
                exp_q.push_back(ev(8'd64, 64'd0));
            end
            K_WRITE: begin
                exp_q.push_back(ev(8'd32, {56'd0, v.addr}));
                exp_q.push_back(ev(8'd33, v.data[64:1]));
                exp_q.push_back(ev(8'd1, 64'd0));
                exp_q.push_back(ev(8'd8, 64'd8));
                exp_q.push_back(ev(8'd64, 64'd0));
            end
            default: exp_q.push_back(ev(8'd64, 64'd0));
        endcase
    endtask

    task automatic run_vector(input vec_t v, input string name);
        int n;
        eeprom_enabled = v.en;
        eeprom_16k     = v.k16;
        mem_rdata_val  = v.rdata;
        t_rx = -1000; t_req = -1000; t_fall = -1000; t_ack = -1000; t_start = -1000;
        push_expected(v);
        rx_length = v.len;
        rx_data   = v.data;
        rx_ready  = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(exp_q.size() == 0 && !rx_ready && !tx_busy && debug_state == 4'd0) && n < 400);
        repeat (4) tick();
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        rx_ready = 1'b0;
        case (v.kind)
            K_INFO: check({name, "_start_latency"}, 64'(t_start - t_rx), 64'd3);
            K_READ: begin
                check({name, "_req_latency"}, 64'(t_req - t_rx), 64'd2);
                check({name, "_ack_to_start"}, 64'(t_start - t_ack), 64'd3);
                check({name, "_req_fall"}, 64'(t_fall - t_ack), 64'd1);
            end
            K_WRITE: begin
                check({name, "_req_latency"}, 64'(t_req - t_rx), 64'd2);
                check({name, "_ack_to_start"}, 64'(t_start - t_ack), 64'd2);
                check({name, "_req_fall"}, 64'(t_fall - t_ack), 64'd1);
            end
            default: ;
        endcase
    endtask

    initial begin
        logic [7:0]  idx;
        logic        k16;
        logic [63:0] rnd;
        vec_t        v;
        int          acks_before;
        int          n;

        checks = 0; failures = 0; cyc = 0;
        mem_delay = 3; mem_rdata_val = 64'd0; ack_count = 0;
        t_rx = -1000; t_req = -1000; t_fall = -1000; t_ack = -1000; t_start = -1000;
        prev_rx = 1'b0; prev_read = 1'b0; prev_write = 1'b0;
        sys_if.reset   = 1'b1;
        eeprom_enabled = 1'b0;
        eeprom_16k     = 1'b0;
        rx_ready       = 1'b0;
        rx_length      = 7'd0;
        rx_data        = 81'd0;

        vecs[0]  = '{7'd9,  f_info(8'h00), 1'b1, 1'b1, 64'd0, K_INFO, 8'h00, {8'h00, ID16, 16'h0000}};
        vecs[1]  = '{7'd9,  f_info(8'hFF), 1'b1, 1'b0, 64'd0, K_INFO, 8'h00, 32'h0080_0000};
        vecs[2]  = '{7'd17, f17(8'h04, 8'h45), 1'b1, 1'b0, 64'h0123_4567_89AB_CDEF, K_READ, 8'h05, 32'd0};
        vecs[3]  = '{7'd81, f81(8'h05, 8'h10, 64'hDEAD_BEEF_CAFE_F00D), 1'b1, 1'b0, 64'd0, K_WRITE, 8'h10, 32'd0};
        vecs[4]  = '{7'd17, f17(8'h05, 8'h00), 1'b1, 1'b0, 64'd0, K_BAD, 8'h00, 32'd0};
        vecs[5]  = '{7'd9,  f_info(8'h00), 1'b0, 1'b0, 64'd0, K_BAD, 8'h00, 32'd0};
        vecs[6]  = '{7'd17, f17(8'h04, 8'h12), 1'b0, 1'b0, 64'd0, K_BAD, 8'h00, 32'd0};
        vecs[7]  = '{7'd17, f17(8'h04, 8'hFF), 1'b1, 1'b1, 64'hFEDC_BA98_7654_3210, K_READ,
                     BUILD_16K ? 8'hFF : 8'h3F, 32'd0};
        vecs[8]  = '{7'd9,  f_info(8'h01), 1'b1, 1'b0, 64'd0, K_BAD, 8'h00, 32'd0};
        vecs[9]  = '{7'd10, f_info(8'h00), 1'b1, 1'b0, 64'd0, K_BAD, 8'h00, 32'd0};
        vecs[10] = '{7'd81, f81(8'h05, 8'hC7, 64'h0011_2233_4455_6677), 1'b1, 1'b1, 64'd0, K_WRITE,
                     BUILD_16K ? 8'hC7 : 8'h07, 32'd0};
        vecs[11] = '{7'd81, f81(8'h04, 8'h10, 64'h1234_0000_5678_0000), 1'b1, 1'b0, 64'd0, K_BAD, 8'h00, 32'd0};
        vecs[12] = '{7'd9,  f_info(8'h00), 1'b1, 1'b0, 64'd0, K_INFO, 8'h00, 32'h0080_0000};

        // Reset state.
        @(posedge sys_if.clk);
        #1;
        repeat (3) tick();
        check("reset_tx_outputs", {20'd0, rx_reset, tx_start, tx_wmask, tx_length, tx_data}, 64'd0);
        check("reset_mem_ctl", {54'd0, mem_read, mem_write, mem_address}, 64'd0);
        check("reset_mem_wdata", mem_wdata, 64'd0);
        check("reset_tx_reset", {63'd0, tx_reset}, 64'd1);
        check("reset_state", {60'd0, debug_state}, 64'd0);
        sys_if.reset = 1'b0;
        tick();
        check("tx_reset_released", {63'd0, tx_reset}, 64'd0);

        // Table-driven frames.
        for (int i = 0; i < 13; i++) begin
            run_vector(vecs[i], $sformatf("vec%0d", i));
        end

        // Randomised read/write blocks.
        for (int i = 0; i < 6; i++) begin
            idx = 8'($urandom_range(0, 255));
            k16 = 1'($urandom_range(0, 1));
            rnd = {32'($urandom), 32'($urandom)};
            mem_delay = $urandom_range(1, 6);
            if (i % 2 == 0) begin
                v = '{7'd17, f17(8'h04, idx), 1'b1, k16, rnd, K_READ,
                      (BUILD_16K && k16) ? idx : {2'b00, idx[5:0]}, 32'd0};
            end else begin
                v = '{7'd81, f81(8'h05, idx, rnd), 1'b1, k16, 64'd0, K_WRITE,
                      (BUILD_16K && k16) ? idx : {2'b00, idx[5:0]}, 32'd0};
            end
            run_vector(v, $sformatf("rnd%0d", i));
        end

        // Reset while a read waits for a slow ack; the late ack must be ignored.
        mem_delay      = 20;
        eeprom_enabled = 1'b1;
        eeprom_16k     = 1'b0;
        mem_rdata_val  = 64'hAAAA_BBBB_CCCC_DDDD;
        t_req = -1000;
        exp_q.push_back(ev(8'd16, 64'h25));
        rx_length = 7'd17;
        rx_data   = f17(8'h04, 8'h25);
        rx_ready  = 1'b1;
        n = 0;
        while (t_req < 0 && n < 20) begin
            tick();
            n++;
        end
        check("rst_req_seen", 64'(exp_q.size()), 64'd0);
        repeat (3) tick();
        check("rst_read_pending", {63'd0, mem_read}, 64'd1);
        acks_before  = ack_count;
        sys_if.reset = 1'b1;
        rx_ready     = 1'b0;
        tick();
        check("rst_drops_read", {63'd0, mem_read}, 64'd0);
        check("rst_tx_reset", {63'd0, tx_reset}, 64'd1);
        tick();
        sys_if.reset = 1'b0;
        repeat (25) tick();
        check("late_ack_fired", 64'(ack_count - acks_before), 64'd1);
        check("late_ack_ignored", {58'd0, mem_read, mem_write, debug_state}, 64'd0);
        check("late_ack_no_tx", {60'd0, tx_start, tx_wmask}, 64'd0);
        mem_delay = 2;
        run_vector(vecs[0], "post_reset_info");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/n64_si_eeprom.md
# n64_si_eeprom

Joybus EEPROM command responder on the CPU side of the SI serial front end. It consumes the received-frame interface (`rx_ready`, `rx_length`, `rx_data`) and decodes EEPROM commands (info, read block, write block). It moves 64-bit blocks through a memory request port and loads the response into the shared shift register through the TX interface (`tx_wmask`, `tx_data`, `tx_length`, `tx_start`). It sits between the SI shifter and the save-memory arbiter.

## Interface
Parameters: none.

Ports:
- `sys.clk`  in  1  system clock; sole clock. Reached through the `if_system.sys` modport.
- `sys.reset`  in  1  synchronous, active-high reset.
- `eeprom_enabled`  in  1  when 0, every frame is discarded and no response is sent.
- `eeprom_16k`  in  1  selects 16 Kbit (1) or 4 Kbit (0); used only with `EEPROM_16K_EN`.
- `rx_ready`  in  1  a complete frame is held in the SI shifter.
- `rx_length`  in  7  received bit count, including the stop bit.
- `rx_data`  in  81  received bits; the last bit received is in [0].
- `rx_reset`  out  1  one-cycle pulse that clears the frame and `rx_ready` in the SI shifter.
- `tx_reset`  out  1  high while `sys.reset` is high, otherwise 0.
- `tx_start`  out  1  one-cycle pulse that starts transmission.
- `tx_busy`  in  1  the SI shifter is transmitting.
- `tx_wmask`  out  3  word-load strobes: [0] loads shifter [80:49], [1] loads [48:17], [2] loads [16:0].
- `tx_length`  out  7  number of response data bits; the shifter appends the stop bit.
- `tx_data`  out  32  word loaded by `tx_wmask`.
- `mem_read`  out  1  block read request; held until `mem_ack`.
- `mem_write`  out  1  block write request; held until `mem_ack`.
- `mem_address`  out  8  64-bit block index.
- `mem_wdata`  out  64  write data.
- `mem_rdata`  in  64  read data; valid in the `mem_ack` cycle.
- `mem_ack`  in  1  one-cycle completion strobe for the current request.

## Operation
- Reset value of every output is 0, except `tx_reset`, which is 1 while `sys.reset` is high. State on reset is `S_IDLE`.

Frame decode, qualified by exact `rx_length`:
- Info: `rx_length`=9 and `rx_data[8:1]` is 0x00 or 0xFF.
- Read: `rx_length`=17 and `rx_data[16:9]`=0x04. Block index is `rx_data[8:1]`.
- Write: `rx_length`=81 and `rx_data[80:73]`=0x05. Block index is `rx_data[72:65]`; data is `rx_data[64:1]`, MSB first.
- Anything else, or `eeprom_enabled`=0: pulse `rx_reset` and return to `S_IDLE`. No TX activity and no memory request.

State machine (all outputs registered):
- `S_IDLE`: on `rx_ready`=1, latch command, index and data; go to `S_DECODE`.
- `S_DECODE`: classify the frame.
  - Info: `tx_data`={0x00, id, 0x00, 0x00}, `tx_wmask`=001, `tx_length`=24; go to `S_START`.
  - Read: assert `mem_read`; go to `S_MEM_READ`.
  - Write: assert `mem_write` with `mem_wdata`; go to `S_MEM_WRITE`.
- `S_MEM_READ`: wait for `mem_ack`. On ack, drop `mem_read`, latch `mem_rdata`, set `tx_data`=rdata[63:32] and `tx_wmask`=001; go to `S_LOAD_LO`.
- `S_LOAD_LO`: `tx_data`=rdata[31:0], `tx_wmask`=010, `tx_length`=64; go to `S_START`.
- `S_MEM_WRITE`: wait for `mem_ack`. On ack, drop `mem_write`, set `tx_data`=0x00000000 (status 0x00), `tx_wmask`=001, `tx_length`=8; go to `S_START`.
- `S_START`: pulse `tx_start` and `rx_reset` together; go to `S_WAIT_BUSY`.
- `S_WAIT_BUSY`: wait for `tx_busy`=1, then go to `S_WAIT_DONE`.
- `S_WAIT_DONE`: wait for `tx_busy`=0, then go to `S_IDLE`.

Id byte: 0x80 for 4K, 0xC0 for 16K.

Address masking: `mem_address` = index & 0x3F for 4K, and the full 8 bits for 16K.

`tx_wmask` is never nonzero for more than one cycle per word.

## Timing
- Info: `tx_start` is high 3 cycles after the cycle in which `rx_ready` is first sampled high.
- Read: `tx_start` follows `mem_ack` by 3 cycles. Write: `tx_start` follows `mem_ack` by 2 cycles.
- `mem_read`/`mem_write` rise 2 cycles after `rx_ready` is sampled, and fall the cycle after `mem_ack`.
- `rx_ready` is ignored outside `S_IDLE`. A frame arriving during transmission is not seen, because the shifter ignores RX while `tx_busy` is high.
- `sys.reset` in any state: return to `S_IDLE` on the next edge and deassert all requests in the same cycle. An in-flight `mem_ack` is dropped.
- `mem_ack` outside `S_MEM_READ`/`S_MEM_WRITE` is ignored.

## Configuration
- `EEPROM_16K_EN` defined: `eeprom_16k` selects the type (id byte and address masking).
- `EEPROM_16K_EN` undefined: 4K only. `eeprom_16k` is ignored, the id byte is always 0x80, and the index is always masked to 6 bits.

## Test plan
- Info: 9-bit frame with command 0x00, `eeprom_16k`=1, 16K build → one `tx_wmask`=001 load of 0x00C00000; `tx_length`=24; `tx_start` and `rx_reset` pulse once.
- Read: command 0x04, index 0x45, 4K mode, memory returns 0x0123456789ABCDEF → `mem_address`=0x05; word loads 0x01234567 (mask 001) then 0x89ABCDEF (mask 010); `tx_length`=64.
- Write: command 0x05, index 0x10, data 0xDEADBEEFCAFEF00D → a single `mem_write` with that `mem_wdata`; response `tx_length`=8, word 0x00000000.
- Invalid frames: `rx_length`=17 with command 0x05, and any frame with `eeprom_enabled`=0 → `rx_reset` pulse only; `tx_start`, `mem_read` and `mem_write` stay 0.
- Reset mid-operation: assert `sys.reset` while `mem_read` is waiting (ack delayed 20 cycles) → `mem_read` drops, a late ack is ignored, and a following info command is answered normally.
- 4K build with `eeprom_16k`=1 → info id is 0x80; read of index 0xFF gives `mem_address`=0x3F.
